// File: rtl/axil_arbiter_if.sv
// Bundled AXI4-Lite signals for the arbiter: flattened per-master upstream buses plus one downstream port.
interface axil_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) ();

  logic [NUM_MASTERS-1:0]            m_awvalid, m_awready;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr;
  logic [NUM_MASTERS-1:0]            m_wvalid, m_wready;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_bvalid, m_bready;
  logic [NUM_MASTERS*2-1:0]          m_bresp;
  logic [NUM_MASTERS-1:0]            m_arvalid, m_arready;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr;
  logic [NUM_MASTERS-1:0]            m_rvalid, m_rready;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata;
  logic [NUM_MASTERS*2-1:0]          m_rresp;

  logic                  s_awvalid, s_awready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_wvalid, s_wready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_bvalid, s_bready;
  logic [1:0]            s_bresp;
  logic                  s_arvalid, s_arready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_rvalid, s_rready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;

  // The arbiter sits on this side: slave to the upstream masters, master toward the register block.
  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_bready,
    input  m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_bready,
    output m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

endinterface

// File: rtl/axil_arbiter.sv
// Shares one AXI4-Lite slave among NUM_MASTERS masters, one transaction in flight at a time.
// Round-robin by default; define AXIL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module axil_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axil_arbiter_if.slave          bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   busy
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef logic [IDXW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                 r_state, w_nextState;
  logic [NUM_MASTERS-1:0] r_grant;
  idx_t                   r_owner;
  logic                   r_awDone, r_wDone, r_arDone;

  logic [NUM_MASTERS-1:0] w_req, w_winnerOneHot;
  idx_t                   w_winner, w_muxIdx;
  logic                   w_anyReq;
  logic                   w_awHs, w_wHs, w_bHs, w_arHs, w_rHs;

`ifndef AXIL_ARB_FIXED_PRIO_EN
  idx_t r_lastWinner;

  function automatic idx_t rrIdx(input idx_t base, input int offset);
    return idx_t'((int'(base) + offset) % NUM_MASTERS);
  endfunction
`endif

  assign w_req          = bus.m_awvalid | bus.m_arvalid;
  assign w_anyReq       = |w_req;
  assign w_winnerOneHot = NUM_MASTERS'(1) << w_winner;

  // Loops run from the farthest candidate to the nearest so the nearest requester overwrites the rest.
  always_comb begin
    w_winner = '0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_req[i]) w_winner = idx_t'(i);
    end
`else
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (w_req[rrIdx(r_lastWinner, i)]) w_winner = rrIdx(r_lastWinner, i);
    end
`endif
  end

  assign w_awHs = bus.s_awvalid & bus.s_awready;
  assign w_wHs  = bus.s_wvalid  & bus.s_wready;
  assign w_bHs  = bus.s_bvalid  & bus.s_bready;
  assign w_arHs = bus.s_arvalid & bus.s_arready;
  assign w_rHs  = bus.s_rvalid  & bus.s_rready;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) w_nextState = bus.m_awvalid[w_winner] ? WRITE : READ;
      end
      WRITE: begin
        if (w_bHs) w_nextState = IDLE;
      end
      READ: begin
        if (w_rHs) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_awDone <= 1'b0;
      r_wDone  <= 1'b0;
      r_arDone <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      r_lastWinner <= idx_t'(NUM_MASTERS - 1);
`endif
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner  <= w_winner;
            r_grant  <= w_winnerOneHot;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
            r_arDone <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            r_lastWinner <= w_winner;
`endif
          end
        end
        WRITE: begin
          if (w_awHs) r_awDone <= 1'b1;
          if (w_wHs)  r_wDone  <= 1'b1;
          if (w_bHs) begin
            r_grant  <= '0;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
          end
        end
        READ: begin
          if (w_arHs) r_arDone <= 1'b1;
          if (w_rHs) begin
            r_grant  <= '0;
            r_arDone <= 1'b0;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  // Idle parks the address/data muxes on master 0; harmless since every valid is low then.
  assign w_muxIdx     = (r_state == IDLE) ? '0 : r_owner;
  assign bus.s_awaddr = bus.m_awaddr[int'(w_muxIdx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.s_araddr = bus.m_araddr[int'(w_muxIdx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.s_wdata  = bus.m_wdata[int'(w_muxIdx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    case (r_state)
      WRITE: begin
        bus.s_awvalid = bus.m_awvalid[r_owner] & ~r_awDone;
        bus.s_wvalid  = bus.m_wvalid[r_owner]  & ~r_wDone;
        bus.s_bready  = bus.m_bready[r_owner];
      end
      READ: begin
        bus.s_arvalid = bus.m_arvalid[r_owner] & ~r_arDone;
        bus.s_rready  = bus.m_rready[r_owner];
      end
      default: ;
    endcase
  end

  // Responses and readies reach the owner only; everyone else sees zeros.
  always_comb begin
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.m_bvalid  = '0;
    bus.m_bresp   = '0;
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    bus.m_rdata   = '0;
    bus.m_rresp   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((r_state == WRITE) && (r_owner == idx_t'(i))) begin
        bus.m_awready[i]      = bus.s_awready & ~r_awDone;
        bus.m_wready[i]       = bus.s_wready  & ~r_wDone;
        bus.m_bvalid[i]       = bus.s_bvalid;
        bus.m_bresp[i*2 +: 2] = bus.s_bresp;
      end
      if ((r_state == READ) && (r_owner == idx_t'(i))) begin
        bus.m_arready[i]                      = bus.s_arready & ~r_arDone;
        bus.m_rvalid[i]                       = bus.s_rvalid;
        bus.m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_rdata;
        bus.m_rresp[i*2 +: 2]                 = bus.s_rresp;
      end
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_axil_arbiter.sv
// Directed bench for axil_arbiter with two masters; the bench plays both the masters and the slave.
module tb_axil_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] grant;
  logic          busy;
  int            cmpCount = 0;
  int            errCount = 0;

  axil_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearInputs;
    bus.m_awvalid = '0; bus.m_awaddr = '0; bus.m_wvalid = '0; bus.m_wdata = '0;
    bus.m_bready  = '0; bus.m_arvalid = '0; bus.m_araddr = '0; bus.m_rready = '0;
    bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bvalid = 1'b0; bus.s_bresp = 2'b00;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0; bus.s_rresp = 2'b00;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Slave side of a read: accept AR now, then present R on the next cycle (left asserted for the caller).
  task automatic slaveReadCycle(input logic [NM-1:0] ownerMask, input logic [DW-1:0] data, input logic [1:0] resp);
    bus.s_arready = 1'b1;
    @(negedge clk);
    bus.m_arvalid = bus.m_arvalid & ~ownerMask;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b1;
    bus.s_rdata   = data;
    bus.s_rresp   = resp;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clearInputs();
    bus.m_awvalid = 2'b01; bus.m_wvalid = 2'b01; bus.m_arvalid = 2'b10;
    bus.s_awready = 1'b1; bus.s_wready = 1'b1; bus.s_arready = 1'b1;
    bus.s_bvalid = 1'b1; bus.s_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b00) begin errCount++; $display("[TB] FAIL rst_grant: got %b want 00", grant); end
    cmpCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    cmpCount++; if (bus.s_awvalid !== 1'b0 || bus.s_wvalid !== 1'b0 || bus.s_arvalid !== 1'b0) begin errCount++; $display("[TB] FAIL rst_svalid: got aw%b w%b ar%b want 0", bus.s_awvalid, bus.s_wvalid, bus.s_arvalid); end
    cmpCount++; if (bus.m_awready !== 2'b00 || bus.m_wready !== 2'b00 || bus.m_arready !== 2'b00) begin errCount++; $display("[TB] FAIL rst_mready: got aw%b w%b ar%b want 00", bus.m_awready, bus.m_wready, bus.m_arready); end
    cmpCount++; if (bus.m_bvalid !== 2'b00 || bus.m_rvalid !== 2'b00) begin errCount++; $display("[TB] FAIL rst_mvalid: got b%b r%b want 00", bus.m_bvalid, bus.m_rvalid); end
    clearInputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    bus.m_awvalid = 2'b01; bus.m_awaddr = {32'hFFFF_0000, 32'h0000_0010};
    bus.m_wvalid  = 2'b01; bus.m_wdata  = {32'h0BAD_0BAD, 32'hDEAD_BEEF};
    bus.m_bready  = 2'b01;
    #1;
    cmpCount++; if (grant !== 2'b00) begin errCount++; $display("[TB] FAIL sw_latency: got %b want 00", grant); end
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b01 || busy !== 1'b1) begin errCount++; $display("[TB] FAIL sw_grant: got %b/%b want 01/1", grant, busy); end
    cmpCount++; if (bus.s_awvalid !== 1'b1 || bus.s_awaddr !== 32'h10) begin errCount++; $display("[TB] FAIL sw_aw: got %b/%h want 1/00000010", bus.s_awvalid, bus.s_awaddr); end
    cmpCount++; if (bus.s_wvalid !== 1'b1 || bus.s_wdata !== 32'hDEADBEEF) begin errCount++; $display("[TB] FAIL sw_w: got %b/%h want 1/deadbeef", bus.s_wvalid, bus.s_wdata); end
    bus.s_awready = 1'b1;
    #1;
    cmpCount++; if (bus.m_awready !== 2'b01 || bus.m_wready !== 2'b00) begin errCount++; $display("[TB] FAIL sw_awready: got aw%b w%b want 01/00", bus.m_awready, bus.m_wready); end
    @(negedge clk);
    bus.s_awready = 1'b0; bus.s_wready = 1'b1;
    #1;
    cmpCount++; if (bus.s_awvalid !== 1'b0) begin errCount++; $display("[TB] FAIL sw_awdone: got %b want 0", bus.s_awvalid); end
    cmpCount++; if (bus.s_wvalid !== 1'b1 || bus.m_wready !== 2'b01) begin errCount++; $display("[TB] FAIL sw_wready: got %b/%b want 1/01", bus.s_wvalid, bus.m_wready); end
    @(negedge clk);
    bus.m_awvalid = 2'b00; bus.m_wvalid = 2'b00; bus.s_wready = 1'b0;
    bus.s_bvalid = 1'b1; bus.s_bresp = 2'b00;
    #1;
    cmpCount++; if (bus.m_bvalid !== 2'b01 || bus.m_bresp !== 4'b0000 || bus.s_bready !== 1'b1) begin errCount++; $display("[TB] FAIL sw_b: got %b/%b/%b want 01/0000/1", bus.m_bvalid, bus.m_bresp, bus.s_bready); end
    cmpCount++; if (grant !== 2'b01) begin errCount++; $display("[TB] FAIL sw_grant_hold: got %b want 01", grant); end
    @(negedge clk);
    bus.s_bvalid = 1'b0;
    #1;
    cmpCount++; if (grant !== 2'b00 || busy !== 1'b0) begin errCount++; $display("[TB] FAIL sw_release: got %b/%b want 00/0", grant, busy); end
    clearInputs();
  endtask

  task automatic test_simultaneous_reads;
    logic [NM-1:0] expSecond, expThird;
    logic [AW-1:0] expAddr;
`ifdef AXIL_ARB_FIXED_PRIO_EN
    expSecond = 2'b01; expThird = 2'b10; expAddr = 32'h104;
`else
    expSecond = 2'b10; expThird = 2'b01; expAddr = 32'h200;
`endif
    doReset();
    bus.m_arvalid = 2'b11; bus.m_araddr = {32'h200, 32'h100}; bus.m_rready = 2'b11;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b01 || bus.s_arvalid !== 1'b1 || bus.s_araddr !== 32'h100) begin errCount++; $display("[TB] FAIL sr_first: got %b/%b/%h want 01/1/00000100", grant, bus.s_arvalid, bus.s_araddr); end
    cmpCount++; if (bus.s_awvalid !== 1'b0 || bus.s_wvalid !== 1'b0) begin errCount++; $display("[TB] FAIL sr_aw_held: got %b/%b want 0/0", bus.s_awvalid, bus.s_wvalid); end
    slaveReadCycle(2'b01, 32'hAAAA_5555, 2'b00);
    cmpCount++; if (bus.m_rvalid !== 2'b01 || bus.m_rdata !== 64'h0000_0000_AAAA_5555) begin errCount++; $display("[TB] FAIL sr_rdata0: got %b/%h want 01/00000000aaaa5555", bus.m_rvalid, bus.m_rdata); end
    @(negedge clk);
    bus.s_rvalid = 1'b0;
    bus.m_arvalid = 2'b11; bus.m_araddr = {32'h200, 32'h104};
    #1;
    cmpCount++; if (grant !== 2'b00 || busy !== 1'b0) begin errCount++; $display("[TB] FAIL sr_gap: got %b/%b want 00/0", grant, busy); end
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== expSecond || bus.s_araddr !== expAddr) begin errCount++; $display("[TB] FAIL sr_second: got %b/%h want %b/%h", grant, bus.s_araddr, expSecond, expAddr); end
    slaveReadCycle(expSecond, 32'h1111_2222, 2'b00);
    cmpCount++; if (bus.m_rvalid !== expSecond) begin errCount++; $display("[TB] FAIL sr_rvalid2: got %b want %b", bus.m_rvalid, expSecond); end
    @(negedge clk);
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== expThird) begin errCount++; $display("[TB] FAIL sr_third: got %b want %b", grant, expThird); end
    slaveReadCycle(expThird, 32'h3333_4444, 2'b00);
    @(negedge clk);
    clearInputs();
    @(negedge clk);
  endtask

  task automatic test_write_read_same;
    bus.m_awvalid = 2'b10; bus.m_arvalid = 2'b10; bus.m_wvalid = 2'b10;
    bus.m_awaddr = {32'h20, 32'h0}; bus.m_araddr = {32'h24, 32'h0};
    bus.m_wdata = {32'hCAFE_F00D, 32'h0}; bus.m_bready = 2'b10; bus.m_rready = 2'b11;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b10 || bus.s_awvalid !== 1'b1 || bus.s_arvalid !== 1'b0) begin errCount++; $display("[TB] FAIL wr_write_first: got %b/%b/%b want 10/1/0", grant, bus.s_awvalid, bus.s_arvalid); end
    cmpCount++; if (bus.s_awaddr !== 32'h20 || bus.s_wdata !== 32'hCAFEF00D) begin errCount++; $display("[TB] FAIL wr_mux: got %h/%h want 00000020/cafef00d", bus.s_awaddr, bus.s_wdata); end
    bus.s_awready = 1'b1; bus.s_wready = 1'b1;
    #1;
    cmpCount++; if (bus.m_awready !== 2'b10 || bus.m_wready !== 2'b10) begin errCount++; $display("[TB] FAIL wr_ready: got %b/%b want 10/10", bus.m_awready, bus.m_wready); end
    @(negedge clk);
    bus.m_awvalid = 2'b00; bus.m_wvalid = 2'b00; bus.s_awready = 1'b0; bus.s_wready = 1'b0;
    bus.s_bvalid = 1'b1; bus.s_bresp = 2'b00;
    #1;
    cmpCount++; if (bus.m_bvalid !== 2'b10) begin errCount++; $display("[TB] FAIL wr_bvalid: got %b want 10", bus.m_bvalid); end
    @(negedge clk);
    bus.s_bvalid = 1'b0;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b10 || bus.s_arvalid !== 1'b1 || bus.s_awvalid !== 1'b0 || bus.s_araddr !== 32'h24) begin errCount++; $display("[TB] FAIL wr_read_next: got %b/%b/%b/%h want 10/1/0/00000024", grant, bus.s_arvalid, bus.s_awvalid, bus.s_araddr); end
    slaveReadCycle(2'b10, 32'h1234_5678, 2'b00);
    cmpCount++; if (bus.m_rvalid !== 2'b10 || bus.m_rdata !== 64'h1234_5678_0000_0000) begin errCount++; $display("[TB] FAIL wr_rdata: got %b/%h want 10/1234567800000000", bus.m_rvalid, bus.m_rdata); end
    @(negedge clk);
    clearInputs();
    @(negedge clk);
  endtask

  task automatic test_error_passthrough;
    bus.m_arvalid = 2'b01; bus.m_araddr = {32'h0, 32'h30}; bus.m_rready = 2'b01;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b01 || bus.m_rvalid !== 2'b00) begin errCount++; $display("[TB] FAIL err_grant: got %b/%b want 01/00", grant, bus.m_rvalid); end
    slaveReadCycle(2'b01, 32'hBAD0_BAD0, 2'b10);
    cmpCount++; if (bus.m_rresp !== 4'b0010 || bus.m_rvalid !== 2'b01) begin errCount++; $display("[TB] FAIL err_rresp: got %b/%b want 0010/01", bus.m_rresp, bus.m_rvalid); end
    @(negedge clk);
    clearInputs();
    @(negedge clk);
  endtask

  task automatic test_back_pressure;
    doReset();
    bus.m_awvalid = 2'b01; bus.m_wvalid = 2'b01; bus.m_bready = 2'b01;
    bus.m_awaddr = {32'h0, 32'h40}; bus.m_wdata = {32'h0, 32'h0000_55AA};
    bus.m_arvalid = 2'b10; bus.m_araddr = {32'h80, 32'h0}; bus.m_rready = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      cmpCount++; if (grant !== 2'b01 || bus.m_awready !== 2'b00 || bus.m_arready !== 2'b00 || bus.s_awvalid !== 1'b1 || bus.s_arvalid !== 1'b0) begin errCount++; $display("[TB] FAIL bp_aw_stall%0d: got g%b awr%b arr%b saw%b sar%b want 01/00/00/1/0", i, grant, bus.m_awready, bus.m_arready, bus.s_awvalid, bus.s_arvalid); end
      @(negedge clk);
    end
    bus.s_awready = 1'b1; bus.s_wready = 1'b1;
    #1;
    cmpCount++; if (bus.m_awready !== 2'b01 || bus.m_wready !== 2'b01) begin errCount++; $display("[TB] FAIL bp_accept: got %b/%b want 01/01", bus.m_awready, bus.m_wready); end
    @(negedge clk);
    bus.m_awvalid = 2'b00; bus.m_wvalid = 2'b00; bus.s_awready = 1'b0; bus.s_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmpCount++; if (grant !== 2'b01 || busy !== 1'b1 || bus.m_bvalid !== 2'b00 || bus.m_arready !== 2'b00) begin errCount++; $display("[TB] FAIL bp_b_wait%0d: got g%b busy%b bv%b arr%b want 01/1/00/00", i, grant, busy, bus.m_bvalid, bus.m_arready); end
      @(negedge clk);
    end
    bus.s_bvalid = 1'b1; bus.s_bresp = 2'b11;
    #1;
    cmpCount++; if (bus.m_bvalid !== 2'b01 || bus.m_bresp !== 4'b0011) begin errCount++; $display("[TB] FAIL bp_decerr: got %b/%b want 01/0011", bus.m_bvalid, bus.m_bresp); end
    @(negedge clk);
    bus.s_bvalid = 1'b0; bus.s_bresp = 2'b00;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b10 || bus.s_araddr !== 32'h80) begin errCount++; $display("[TB] FAIL bp_next_owner: got %b/%h want 10/00000080", grant, bus.s_araddr); end
    slaveReadCycle(2'b10, 32'h0, 2'b00);
    @(negedge clk);
    clearInputs();
    @(negedge clk);
  endtask

  task automatic test_mid_write_reset;
    bus.m_awvalid = 2'b01; bus.m_wvalid = 2'b01; bus.m_awaddr = {32'h0, 32'h50};
    bus.m_bready = 2'b01;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b01 || bus.s_awvalid !== 1'b1) begin errCount++; $display("[TB] FAIL mr_pre: got %b/%b want 01/1", grant, bus.s_awvalid); end
    bus.s_awready = 1'b1; bus.s_wready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    cmpCount++; if (grant !== 2'b00 || busy !== 1'b0) begin errCount++; $display("[TB] FAIL mr_grant: got %b/%b want 00/0", grant, busy); end
    cmpCount++; if (bus.s_awvalid !== 1'b0 || bus.s_wvalid !== 1'b0 || bus.m_awready !== 2'b00 || bus.m_wready !== 2'b00) begin errCount++; $display("[TB] FAIL mr_handshake: got %b/%b/%b/%b want 0/0/00/00", bus.s_awvalid, bus.s_wvalid, bus.m_awready, bus.m_wready); end
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.m_arvalid = 2'b11; bus.m_rready = 2'b11;
    @(negedge clk);
    #1;
    cmpCount++; if (grant !== 2'b01) begin errCount++; $display("[TB] FAIL mr_first_after: got %b want 01", grant); end
    slaveReadCycle(2'b01, 32'h0, 2'b00);
    @(negedge clk);
    clearInputs();
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_single_write();
    test_simultaneous_reads();
    test_write_read_same();
    test_error_passthrough();
    test_back_pressure();
    test_mid_write_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
